// File: rtl/ah_demux_route_ctrl.sv
// rtl/ah_demux_route_ctrl.sv - packet framing, destination decode and skid-buffered select for the egress demux
// Head flits pick the egress; out-of-range packets are discarded and counted.
module ah_demux_route_ctrl #(
   parameter int DATA_W   = 36,
   parameter int NUM_EGR  = 27,
   parameter int SEL_W    = 5,
   parameter int DEST_LSB = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ing_data,
   input  logic              ing_valid,
   output logic              ing_ready,
   output logic [DATA_W-1:0] egr_data,
   output logic              egr_valid,
   input  logic              egr_ready,
   output logic [SEL_W-1:0]  egr_sel,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              drop_pulse
);

   typedef enum logic [1:0] {ST_HEAD, ST_BODY, ST_DROP} state_t;

   localparam logic [SEL_W:0] NUM_EGR_W = (SEL_W+1)'(NUM_EGR);

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [SEL_W-1:0]  main_sel_q, main_sel_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [SEL_W-1:0]  skid_sel_q, skid_sel_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic              drop_pulse_q, drop_pulse_d;

   logic              accept, deliver, last, dest_ok, enq, drop;
   logic [SEL_W-1:0]  dest, enq_sel;

   assign ing_ready = !skid_valid_q;
   assign accept    = ing_valid && !skid_valid_q;
   assign deliver   = main_valid_q && egr_ready;
   assign last      = ing_data[DATA_W-1];
   assign dest      = ing_data[DEST_LSB +: SEL_W];
   assign dest_ok   = ({1'b0, dest} < NUM_EGR_W);

   assign egr_valid  = main_valid_q;
   assign egr_data   = main_data_q;
   assign egr_sel    = main_sel_q;
   assign drop_cnt   = drop_cnt_q;
   assign drop_pulse = drop_pulse_q;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      enq          = 1'b0;
      drop         = 1'b0;
      enq_sel      = sel_q;
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_sel_d   = main_sel_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_sel_d   = skid_sel_q;

      if (accept) begin
         case (state_q)
            ST_HEAD: begin
               if (dest_ok) begin
                  enq     = 1'b1;
                  enq_sel = dest;
                  sel_d   = dest;
                  if (!last) state_d = ST_BODY;
               end else begin
                  drop = 1'b1;
                  if (!last) state_d = ST_DROP;
               end
            end
            ST_BODY: begin
               enq = 1'b1;
               if (last) state_d = ST_HEAD;
            end
            ST_DROP: begin
               if (last) state_d = ST_HEAD;
            end
            default: state_d = ST_HEAD;
         endcase
      end

      // A full skid implies ing_ready=0, so no enqueue can coincide with it.
      if (skid_valid_q) begin
         if (deliver) begin
            main_data_d  = skid_data_q;
            main_sel_d   = skid_sel_q;
            skid_valid_d = 1'b0;
         end
      end else if (enq) begin
         if (!main_valid_q || deliver) begin
            main_valid_d = 1'b1;
            main_data_d  = ing_data;
            main_sel_d   = enq_sel;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = ing_data;
            skid_sel_d   = enq_sel;
         end
      end else if (deliver) begin
         main_valid_d = 1'b0;
      end

      drop_pulse_d = drop;
      drop_cnt_d   = (drop && (drop_cnt_q != {CNT_W{1'b1}})) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_HEAD;
         sel_q        <= '0;
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_sel_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_sel_q   <= '0;
         drop_cnt_q   <= '0;
         drop_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_sel_q   <= main_sel_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_sel_q   <= skid_sel_d;
         drop_cnt_q   <= drop_cnt_d;
         drop_pulse_q <= drop_pulse_d;
      end
   end

endmodule

// File: tb/tb_ah_demux_route_ctrl.sv
// tb/tb_ah_demux_route_ctrl.sv - directed and randomized checks of ah_demux_route_ctrl against a packet-level model
module tb_ah_demux_route_ctrl;

   localparam int DATA_W  = 36;
   localparam int NUM_EGR = 27;
   localparam int SEL_W   = 5;
   localparam int CNT_W   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] ing_data = '0;
   logic              ing_valid = 1'b0;
   logic              ing_ready;
   logic [DATA_W-1:0] egr_data;
   logic              egr_valid;
   logic              egr_ready = 1'b0;
   logic [SEL_W-1:0]  egr_sel;
   logic [CNT_W-1:0]  drop_cnt;
   logic              drop_pulse;

   ah_demux_route_ctrl #(
      .DATA_W(DATA_W), .NUM_EGR(NUM_EGR), .SEL_W(SEL_W), .DEST_LSB(0), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .ing_data(ing_data), .ing_valid(ing_valid), .ing_ready(ing_ready),
      .egr_data(egr_data), .egr_valid(egr_valid), .egr_ready(egr_ready),
      .egr_sel(egr_sel), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: expected egress entries {data, sel}, packet framing flags, drop tally.
   logic [DATA_W+SEL_W-1:0] exp_q[$];
   bit                      in_pkt, dropping, exp_pulse;
   logic [SEL_W-1:0]        cur_sel;
   int                      drops;
   int                      pulse_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mk(input bit lst, input logic [29:0] pay, input logic [4:0] dst);
      return {lst, pay, dst};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      in_pkt    = 0;
      dropping  = 0;
      exp_pulse = 0;
      cur_sel   = '0;
      drops     = 0;
   endtask

   task automatic model_accept(input logic [DATA_W-1:0] d);
      int dst;
      dst = int'(d[SEL_W-1:0]);
      if (!in_pkt) begin
         if (dst < NUM_EGR) begin
            exp_q.push_back({d, d[SEL_W-1:0]});
            cur_sel  = d[SEL_W-1:0];
            dropping = 0;
         end else begin
            drops++;
            exp_pulse = 1;
            dropping  = 1;
         end
         in_pkt = !d[DATA_W-1];
      end else begin
         if (!dropping) exp_q.push_back({d, cur_sel});
         if (d[DATA_W-1]) in_pkt = 0;
      end
   endtask

   task automatic compare_outputs();
      int sat;
      sat = (drops > 3) ? 3 : drops;
      check("egr_valid", 64'(egr_valid), 64'(exp_q.size() > 0));
      check("ing_ready", 64'(ing_ready), 64'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
         check("egr_data", 64'(egr_data), 64'(exp_q[0][DATA_W+SEL_W-1:SEL_W]));
         check("egr_sel", 64'(egr_sel), 64'(exp_q[0][SEL_W-1:0]));
      end
      check("drop_pulse", 64'(drop_pulse), 64'(exp_pulse));
      check("drop_cnt", 64'(drop_cnt), 64'(sat));
      if (drop_pulse) pulse_seen++;
   endtask

   task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic er, output bit acc);
      bit dlv;
      @(negedge clk);
      ing_valid = v;
      ing_data  = d;
      egr_ready = er;
      acc = v && (exp_q.size() < 2);
      dlv = (exp_q.size() > 0) && er;
      @(posedge clk);
      #1;
      exp_pulse = 0;
      if (dlv) void'(exp_q.pop_front());
      if (acc) model_accept(d);
      compare_outputs();
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic er);
      bit acc;
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, d, er, acc);
      if (!acc) check("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b1, acc);
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      cycle(1'b0, '0, 1'b1, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      ing_valid = 0;
      rst = 1;
      #1;
      model_reset();
      check("rst_egr_valid", 64'(egr_valid), 64'(0));
      check("rst_egr_data", 64'(egr_data), 64'(0));
      check("rst_egr_sel", 64'(egr_sel), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
      check("rst_drop_pulse", 64'(drop_pulse), 64'(0));
      check("rst_ing_ready", 64'(ing_ready), 64'(1));
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      bit acc;
      int len, gaps;
      logic [4:0] dst;
      model_reset();
      do_reset();

      // single-flit packet to egress 5
      send(mk(1, 30'h1234567, 5'd5), 1);
      drain();

      // 4-flit packet to egress 26, back-to-back
      send(mk(0, 30'h0aaaaaa, 5'd26), 1);
      send(mk(0, 30'h0000011, 5'd3), 1);
      send(mk(0, 30'h0000022, 5'd3), 1);
      send(mk(1, 30'h0000033, 5'd3), 1);
      drain();

      // dropped 3-flit packet, then a packet to egress 0
      pulse_seen = 0;
      send(mk(0, 30'h0bbbbbb, 5'd27), 1);
      send(mk(0, 30'h0000001, 5'd1), 1);
      send(mk(1, 30'h0000002, 5'd2), 1);
      send(mk(1, 30'h0cccccc, 5'd0), 1);
      drain();
      check("drop_pulse_cycles", 64'(pulse_seen), 64'(1));

      // backpressure: A, B buffered, C blocked until release
      send(mk(0, 30'h00000a1, 5'd9), 0);
      send(mk(0, 30'h00000b2, 5'd9), 0);
      cycle(1'b1, mk(1, 30'h00000c3, 5'd9), 1'b0, acc);
      check("c_blocked", 64'(acc), 64'(0));
      cycle(1'b1, mk(1, 30'h00000c3, 5'd9), 1'b0, acc);
      send(mk(1, 30'h00000c3, 5'd9), 1);
      drain();

      // reset mid-packet, then a packet to egress 7
      send(mk(0, 30'h0dddddd, 5'd3), 0);
      send(mk(0, 30'h0000044, 5'd3), 0);
      do_reset();
      send(mk(1, 30'h0eeeeee, 5'd7), 1);
      drain();

      // counter saturation at 3 over 5 drops
      pulse_seen = 0;
      for (int i = 0; i < 5; i++) send(mk(1, 30'(i), 5'(27 + (i % 5))), 1);
      drain();
      check("sat_pulses", 64'(pulse_seen), 64'(5));
      check("sat_cnt", 64'(drop_cnt), 64'(3));

      // randomized packets, gaps and backpressure
      do_reset();
      for (int p = 0; p < 300; p++) begin
         len = $urandom_range(1, 5);
         dst = 5'($urandom_range(0, 31));
         for (int f = 0; f < len; f++) begin
            gaps = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < gaps; g++) cycle(1'b0, DATA_W'($urandom), 1'($urandom), acc);
            acc = 0;
            for (int t = 0; t < 60 && !acc; t++)
               cycle(1'b1, mk(f == len - 1, 30'($urandom), (f == 0) ? dst : 5'($urandom)),
                     ($urandom_range(0, 3) != 0), acc);
            if (!acc) check("rand_send_timeout", 64'(0), 64'(1));
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
